// File: rtl/mips_mem_pkg.sv
// Shared encodings and helpers for the MEM-stage data memory access path.
package mips_mem_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    MERGE = 2'b10
  } mau_state_e;

  // Captured sub-word request, held across the stall cycle.
  typedef struct packed {
    logic [1:0]        lane;
    logic [1:0]        size;
    logic              is_unsigned;
    logic [DATA_W-1:0] wr_data;
  } mem_req_t;

  // Encoding 2'b10 is reserved and behaves as a word access.
  function automatic logic is_word(input logic [1:0] size);
    return size[1];
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic mis;
    mis = 1'b0;
    if (is_word(size)) begin
      mis = (lane != 2'b00);
    end else if (size == SZ_HALF) begin
      mis = lane[0];
    end
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte/halfword lane selection with sign/zero extension for loads, and
// sub-word insertion into a read word for read-modify-write stores.
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [DATA_W-1:0] rd_data,
  input  logic [1:0]        lane,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] load_data_c,
  output logic [DATA_W-1:0] merge_data_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        fill;

  always_comb begin
    byte_sel     = rd_data[{lane, 3'b000} +: 8];
    half_sel     = rd_data[{lane[1], 4'b0000} +: 16];
    fill         = 1'b0;
    load_data_c  = rd_data;
    merge_data_c = rd_data;
    case (size)
      SZ_BYTE: begin
        fill = ~is_unsigned & byte_sel[7];
        load_data_c = {{24{fill}}, byte_sel};
        merge_data_c[{lane, 3'b000} +: 8] = wr_data[7:0];
      end
      SZ_HALF: begin
        fill = ~is_unsigned & half_sel[15];
        load_data_c = {{16{fill}}, half_sel};
        merge_data_c[{lane[1], 4'b0000} +: 16] = wr_data[15:0];
      end
      default: begin
        load_data_c  = rd_data;
        merge_data_c = wr_data;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage controller: turns sized loads/stores into word accesses on a
// 1-cycle-latency single-port RAM, stalling one cycle for loads and sub-word stores.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int unsigned RAM_DEPTH = 1024,
  parameter int unsigned ADDR_W    = $clog2(RAM_DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_wr_data,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [31:0]       o_ram_data,
  output logic              o_ram_we,
  input  logic [31:0]       i_ram_data,
  output logic [31:0]       o_load_data,
  output logic              o_load_valid,
  output logic              o_stall,
  output logic              o_misaligned
);

  mau_state_e        state_q, state_d;
  mem_req_t          req_q;
  logic [ADDR_W-1:0] req_waddr_q;
  logic [31:0]       load_data_q;
  logic              load_valid_q;

  logic              capture_c;
  logic              load_fire_c;
  logic              misaligned_c;
  logic [31:0]       lane_load_c;
  logic [31:0]       lane_merge_c;

  // Byte-address bits above the RAM range are dropped so accesses wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^i_addr[31:ADDR_W+2];

  assign misaligned_c = is_misaligned(i_size, i_addr[1:0]);

  mem_lane_align u_lane_align (
    .rd_data      (i_ram_data),
    .lane         (req_q.lane),
    .size         (req_q.size),
    .is_unsigned  (req_q.is_unsigned),
    .wr_data      (req_q.wr_data),
    .load_data_c  (lane_load_c),
    .merge_data_c (lane_merge_c)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and RAM-side strobes; reset forces every strobe low.
  always_comb begin
    state_d      = state_q;
    o_ram_addr   = i_addr[ADDR_W+1:2];
    o_ram_data   = i_wr_data;
    o_ram_we     = 1'b0;
    o_stall      = 1'b0;
    o_misaligned = 1'b0;
    capture_c    = 1'b0;
    load_fire_c  = 1'b0;
    if (i_rst) begin
      state_d    = IDLE;
      o_ram_addr = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_mem_write) begin
            if (misaligned_c) begin
              o_misaligned = 1'b1;
            end else if (is_word(i_size)) begin
              o_ram_we = 1'b1;
            end else begin
              o_stall   = 1'b1;
              capture_c = 1'b1;
              state_d   = MERGE;
            end
          end else if (i_mem_read) begin
            if (misaligned_c) begin
              o_misaligned = 1'b1;
            end else begin
              o_stall   = 1'b1;
              capture_c = 1'b1;
              state_d   = LOAD;
            end
          end
        end
        LOAD: begin
          o_ram_addr  = req_waddr_q;
          load_fire_c = 1'b1;
          state_d     = IDLE;
        end
        MERGE: begin
          o_ram_addr = req_waddr_q;
          o_ram_data = lane_merge_c;
          o_ram_we   = 1'b1;
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      req_q        <= '0;
      req_waddr_q  <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
    end else begin
      if (capture_c) begin
        req_q.lane        <= i_addr[1:0];
        req_q.size        <= i_size;
        req_q.is_unsigned <= i_unsigned;
        req_q.wr_data     <= i_wr_data;
        req_waddr_q       <= i_addr[ADDR_W+1:2];
      end
      if (load_fire_c) begin
        load_data_q <= lane_load_c;
      end
      load_valid_q <= load_fire_c;
    end
  end

  assign o_load_data  = load_data_q;
  assign o_load_valid = load_valid_q;

endmodule
